// File: rtl/player_pkg.sv
// Shared definitions for the player pose integrator: FSM states, button indices, widths.
// Optional feature macro used by consumers: GRAVITY_EN.
package player_pkg;
    localparam int POS_W    = 17;
    localparam int ANG_W    = 16;
    localparam int POS_FRAC = 7;
    localparam int DEG_360  = 360;
    localparam int YAW_W    = 9;
    localparam int BTN_W    = 10;

    localparam int BTN_FWD    = 0;
    localparam int BTN_BACK   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_TURN_L = 4;
    localparam int BTN_TURN_R = 5;
    localparam int BTN_LOOK_U = 6;
    localparam int BTN_LOOK_D = 7;
    localparam int BTN_UP     = 8;
    localparam int BTN_DOWN   = 9;

    typedef enum logic [2:0] {IDLE, ROTATE, LOOKUP, MOVE, COMMIT} state_t;

    function automatic logic [POS_W-1:0] clamp_pos(input int v, input int hi);
        if (v < 0)
            return '0;
        else if (v > hi)
            return POS_W'(hi);
        else
            return POS_W'(v);
    endfunction
endpackage

// File: rtl/player_ctrl_trig.sv
// Quarter-wave sine/cosine table for yaw 0..359, signed Q1.7 outputs.
// Latency: 1 cycle (registered outputs). No backpressure; address may change every cycle.
module trig_lut
    import player_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [YAW_W-1:0]   yaw,
    output logic signed [7:0]  cos,
    output logic signed [7:0]  sin
);
    // round(127*sin(k deg)), k = 0..90
    localparam int QTAB [0:90] = '{
        0,   2,   4,   7,   9,   11,  13,  15,  18,  20,  22,  24,  26,
        29,  31,  33,  35,  37,  39,  41,  43,  46,  48,  50,  52,  54,
        56,  58,  60,  62,  64,  65,  67,  69,  71,  73,  75,  76,  78,
        80,  82,  83,  85,  87,  88,  90,  91,  93,  94,  96,  97,  99,
        100, 101, 103, 104, 105, 107, 108, 109, 110, 111, 112, 113, 114,
        115, 116, 117, 118, 119, 119, 120, 121, 121, 122, 123, 123, 124,
        124, 125, 125, 125, 126, 126, 126, 127, 127, 127, 127, 127, 127
    };

    logic [6:0] s_idx, c_idx;
    logic       s_neg, c_neg;

    always_comb begin
        s_idx = '0;
        c_idx = '0;
        s_neg = 1'b0;
        c_neg = 1'b0;
        if (yaw <= 9'd90) begin
            s_idx = 7'(yaw);
            c_idx = 7'(9'd90 - yaw);
        end else if (yaw <= 9'd180) begin
            s_idx = 7'(9'd180 - yaw);
            c_idx = 7'(yaw - 9'd90);
            c_neg = 1'b1;
        end else if (yaw <= 9'd270) begin
            s_idx = 7'(yaw - 9'd180);
            c_idx = 7'(9'd270 - yaw);
            s_neg = 1'b1;
            c_neg = 1'b1;
        end else begin
            s_idx = 7'(9'd360 - yaw);
            c_idx = 7'(yaw - 9'd270);
            s_neg = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos <= '0;
            sin <= '0;
        end else begin
            cos <= c_neg ? -8'(QTAB[c_idx]) : 8'(QTAB[c_idx]);
            sin <= s_neg ? -8'(QTAB[s_idx]) : 8'(QTAB[s_idx]);
        end
    end
endmodule

// File: rtl/player_ctrl.sv
// Per-frame player pose integrator; optional vertical physics under GRAVITY_EN.
// Latency: tick sampled at E0, pose outputs and pose_update registered at E4.
// No backpressure: ticks arriving while an update is in flight (E1..E3) are dropped.
module player_ctrl
    import player_pkg::*;
#(
    parameter int INIT_X     = 33 << 10,
    parameter int INIT_Y     = 33 << 10,
    parameter int INIT_Z     = 49 << 10,
    parameter int INIT_YAW   = 225,
    parameter int MOVE_SPEED = 64,
    parameter int TURN_STEP  = 3,
    parameter int PITCH_MAX  = 60,
    parameter int POS_MAX    = 65535
`ifdef GRAVITY_EN
   ,parameter int GRAVITY    = 4,
    parameter int JUMP_VEL   = 96,
    parameter int MAX_FALL   = 256,
    parameter int FLOOR_Y    = 8 << 10
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic [BTN_W-1:0]        btn,
    output logic [POS_W-1:0]        p_pos_x,
    output logic [POS_W-1:0]        p_pos_y,
    output logic [POS_W-1:0]        p_pos_z,
    output logic [ANG_W-1:0]        p_angle_x,
    output logic signed [ANG_W-1:0] p_angle_y,
    output logic                    pose_update
);
    state_t                  state, state_nxt;
    logic                    accept;
    logic [BTN_W-1:0]        btn_q;
    logic [YAW_W-1:0]        yaw_w, yaw_nxt;
    logic signed [ANG_W-1:0] pitch_w, pitch_nxt;
    logic [POS_W-1:0]        x_w, y_w, z_w, x_nxt, y_nxt, z_nxt;
    logic signed [7:0]       cos_v, sin_v;
    int                      yaw_i, pitch_i, c_i, s_i, dx_i, dz_i, y_i;
`ifdef GRAVITY_EN
    logic signed [11:0]      vel_y, vel_nxt;
    int                      vel_i;
`endif

    trig_lut u_trig (
        .clk   (clk),
        .rst_n (rst_n),
        .yaw   (yaw_w),
        .cos   (cos_v),
        .sin   (sin_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // COMMIT doubles as an idle cycle so a tick landing on E4 is not lost.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, COMMIT: begin
                accept    = frame_tick;
                state_nxt = frame_tick ? ROTATE : IDLE;
            end
            ROTATE:  state_nxt = LOOKUP;
            LOOKUP:  state_nxt = MOVE;
            MOVE:    state_nxt = COMMIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        yaw_i = int'(yaw_w);
        if (btn_q[BTN_TURN_L]) yaw_i = yaw_i + TURN_STEP;
        if (btn_q[BTN_TURN_R]) yaw_i = yaw_i - TURN_STEP;
        if (yaw_i >= DEG_360)
            yaw_i = yaw_i - DEG_360;
        else if (yaw_i < 0)
            yaw_i = yaw_i + DEG_360;

        pitch_i = int'(pitch_w);
        if (btn_q[BTN_LOOK_U] && !btn_q[BTN_LOOK_D])
            pitch_i = (pitch_i + TURN_STEP > PITCH_MAX) ? PITCH_MAX : pitch_i + TURN_STEP;
        if (btn_q[BTN_LOOK_D] && !btn_q[BTN_LOOK_U])
            pitch_i = (pitch_i - TURN_STEP < -PITCH_MAX) ? -PITCH_MAX : pitch_i - TURN_STEP;

        yaw_nxt   = YAW_W'(yaw_i);
        pitch_nxt = ANG_W'(pitch_i);
    end

    always_comb begin
        c_i  = (MOVE_SPEED * int'(cos_v)) >>> 7;
        s_i  = (MOVE_SPEED * int'(sin_v)) >>> 7;
        dx_i = 0;
        dz_i = 0;
        if (btn_q[BTN_FWD])   begin dx_i = dx_i + c_i; dz_i = dz_i + s_i; end
        if (btn_q[BTN_BACK])  begin dx_i = dx_i - c_i; dz_i = dz_i - s_i; end
        if (btn_q[BTN_RIGHT]) begin dx_i = dx_i - s_i; dz_i = dz_i + c_i; end
        if (btn_q[BTN_LEFT])  begin dx_i = dx_i + s_i; dz_i = dz_i - c_i; end
        x_nxt = clamp_pos(int'(x_w) + dx_i, POS_MAX);
        z_nxt = clamp_pos(int'(z_w) + dz_i, POS_MAX);

        y_i = int'(y_w);
`ifdef GRAVITY_EN
        vel_i = int'(vel_y) - GRAVITY;
        if (vel_i < -MAX_FALL) vel_i = -MAX_FALL;
        if (btn_q[BTN_UP] && int'(y_w) == FLOOR_Y) vel_i = JUMP_VEL;
        y_i = y_i + vel_i;
        if (y_i <= FLOOR_Y) begin
            y_i   = FLOOR_Y;
            vel_i = 0;
        end
        vel_nxt = 12'(vel_i);
`else
        if (btn_q[BTN_UP])   y_i = y_i + MOVE_SPEED;
        if (btn_q[BTN_DOWN]) y_i = y_i - MOVE_SPEED;
`endif
        y_nxt = clamp_pos(y_i, POS_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q       <= '0;
            yaw_w       <= YAW_W'(INIT_YAW);
            pitch_w     <= '0;
            x_w         <= POS_W'(INIT_X);
            y_w         <= POS_W'(INIT_Y);
            z_w         <= POS_W'(INIT_Z);
            p_pos_x     <= POS_W'(INIT_X);
            p_pos_y     <= POS_W'(INIT_Y);
            p_pos_z     <= POS_W'(INIT_Z);
            p_angle_x   <= ANG_W'(INIT_YAW);
            p_angle_y   <= '0;
            pose_update <= 1'b0;
`ifdef GRAVITY_EN
            vel_y       <= '0;
`endif
        end else begin
            pose_update <= (state == COMMIT);
            if (accept)
                btn_q <= btn;
            if (state == ROTATE) begin
                yaw_w   <= yaw_nxt;
                pitch_w <= pitch_nxt;
            end
            if (state == MOVE) begin
                x_w <= x_nxt;
                y_w <= y_nxt;
                z_w <= z_nxt;
`ifdef GRAVITY_EN
                vel_y <= vel_nxt;
`endif
            end
            if (state == COMMIT) begin
                p_pos_x   <= x_w;
                p_pos_y   <= y_w;
                p_pos_z   <= z_w;
                p_angle_x <= ANG_W'(yaw_w);
                p_angle_y <= pitch_w;
            end
        end
    end
endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: reset, latency, dropped/back-to-back ticks, yaw wrap,
// movement per heading, position and pitch clamps, vertical motion (GRAVITY_EN aware).
module tb_player_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  btn = '0;
    logic [16:0] p_pos_x, p_pos_y, p_pos_z;
    logic [15:0] p_angle_x;
    logic signed [15:0] p_angle_y;
    logic        pose_update;

    int vectors = 0;
    int errors  = 0;
    int ex_x, ex_z;

    localparam logic [9:0] B_FWD = 10'h001, B_BACK = 10'h002, B_LEFT = 10'h004, B_RIGHT = 10'h008;
    localparam logic [9:0] B_TL = 10'h010, B_TR = 10'h020, B_LU = 10'h040, B_LD = 10'h080;
    localparam logic [9:0] B_UP = 10'h100, B_DN = 10'h200;

    player_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn        (btn),
        .p_pos_x    (p_pos_x),
        .p_pos_y    (p_pos_y),
        .p_pos_z    (p_pos_z),
        .p_angle_x  (p_angle_x),
        .p_angle_y  (p_angle_y),
        .pose_update(pose_update)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick_frame(input logic [9:0] b);
        bit got;
        @(negedge clk); frame_tick = 1'b1; btn = b;
        @(negedge clk); frame_tick = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = pose_update;
        end
        btn = '0;
        if (!got) begin
            vectors++; errors++;
            $display("FAIL frame_timeout pose_update=0 required 1 within 8 cycles");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; frame_tick = 1'b0; btn = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (p_pos_x !== 17'd33792) begin errors++; $display("FAIL reset_x got %0d exp 33792", p_pos_x); end
        vectors++; if (p_pos_y !== 17'd33792) begin errors++; $display("FAIL reset_y got %0d exp 33792", p_pos_y); end
        vectors++; if (p_pos_z !== 17'd50176) begin errors++; $display("FAIL reset_z got %0d exp 50176", p_pos_z); end
        vectors++; if (p_angle_x !== 16'd225) begin errors++; $display("FAIL reset_yaw got %0d exp 225", p_angle_x); end
        vectors++; if (p_angle_y !== 16'sd0) begin errors++; $display("FAIL reset_pitch got %0d exp 0", p_angle_y); end
        vectors++; if (pose_update !== 1'b0) begin errors++; $display("FAIL reset_pu got %b exp 0", pose_update); end
    endtask

    task automatic test_reset_abort;
        bit saw;
        @(negedge clk); frame_tick = 1'b1; btn = B_FWD | B_TL;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (p_pos_x !== 17'd33792) begin errors++; $display("FAIL abort_x got %0d exp 33792", p_pos_x); end
        vectors++; if (p_angle_x !== 16'd225) begin errors++; $display("FAIL abort_yaw got %0d exp 225", p_angle_x); end
        saw = 1'b0;
        repeat (2) begin @(negedge clk); saw |= pose_update; end
        rst_n = 1'b1; btn = '0;
        repeat (8) begin @(negedge clk); saw |= pose_update; end
        vectors++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_pu got %b exp 0", saw); end
        vectors++; if (p_pos_x !== 17'd33792) begin errors++; $display("FAIL abort_x_after got %0d exp 33792", p_pos_x); end
        vectors++; if (p_angle_x !== 16'd225) begin errors++; $display("FAIL abort_yaw_after got %0d exp 225", p_angle_x); end
    endtask

    task automatic test_latency_drop;
        int pulses;
        @(negedge clk); frame_tick = 1'b1; btn = B_TL;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        vectors++; if (p_angle_x !== 16'd225 || pose_update !== 1'b0) begin errors++; $display("FAIL lat_e1 yaw %0d pu %b exp 225/0", p_angle_x, pose_update); end
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        vectors++; if (p_angle_x !== 16'd225 || pose_update !== 1'b0) begin errors++; $display("FAIL lat_e2 yaw %0d pu %b exp 225/0", p_angle_x, pose_update); end
        @(negedge clk);
        vectors++; if (p_angle_x !== 16'd225 || pose_update !== 1'b0) begin errors++; $display("FAIL lat_e3 yaw %0d pu %b exp 225/0", p_angle_x, pose_update); end
        @(negedge clk);
        vectors++; if (p_angle_x !== 16'd228 || pose_update !== 1'b1) begin errors++; $display("FAIL lat_e4 yaw %0d pu %b exp 228/1", p_angle_x, pose_update); end
        @(negedge clk);
        vectors++; if (pose_update !== 1'b0) begin errors++; $display("FAIL lat_e5 pu %b exp 0", pose_update); end
        btn = '0;
        pulses = 0;
        repeat (8) begin @(negedge clk); if (pose_update) pulses++; end
        vectors++; if (pulses != 0) begin errors++; $display("FAIL drop_pulses got %0d exp 0", pulses); end
        vectors++; if (p_angle_x !== 16'd228) begin errors++; $display("FAIL drop_yaw got %0d exp 228", p_angle_x); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); frame_tick = 1'b1; btn = B_TR;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        vectors++; if (p_angle_x !== 16'd225 || pose_update !== 1'b1) begin errors++; $display("FAIL b2b_first yaw %0d pu %b exp 225/1", p_angle_x, pose_update); end
        repeat (3) @(negedge clk);
        vectors++; if (p_angle_x !== 16'd225 || pose_update !== 1'b0) begin errors++; $display("FAIL b2b_gap yaw %0d pu %b exp 225/0", p_angle_x, pose_update); end
        @(negedge clk);
        vectors++; if (p_angle_x !== 16'd222 || pose_update !== 1'b1) begin errors++; $display("FAIL b2b_second yaw %0d pu %b exp 222/1", p_angle_x, pose_update); end
        btn = '0;
    endtask

    task automatic test_yaw_wrap;
        repeat (45) tick_frame(B_TL);
        vectors++; if (p_angle_x !== 16'd357) begin errors++; $display("FAIL wrap_357 got %0d exp 357", p_angle_x); end
        tick_frame(B_TL);
        vectors++; if (p_angle_x !== 16'd0) begin errors++; $display("FAIL wrap_up got %0d exp 0", p_angle_x); end
        tick_frame(B_TR);
        vectors++; if (p_angle_x !== 16'd357) begin errors++; $display("FAIL wrap_down got %0d exp 357", p_angle_x); end
        tick_frame(B_TL | B_TR);
        vectors++; if (p_angle_x !== 16'd357) begin errors++; $display("FAIL turn_cancel got %0d exp 357", p_angle_x); end
        tick_frame(B_TL);
        vectors++; if (p_angle_x !== 16'd0) begin errors++; $display("FAIL wrap_back got %0d exp 0", p_angle_x); end
    endtask

    task automatic test_move;
        ex_x = 33792; ex_z = 50176;
        tick_frame(B_FWD); ex_x += 63;
        vectors++; if (p_pos_x !== 17'(ex_x) || p_pos_z !== 17'(ex_z)) begin errors++; $display("FAIL fwd0 x %0d z %0d exp %0d %0d", p_pos_x, p_pos_z, ex_x, ex_z); end
        tick_frame(B_BACK); ex_x -= 63;
        vectors++; if (p_pos_x !== 17'(ex_x)) begin errors++; $display("FAIL back0 x %0d exp %0d", p_pos_x, ex_x); end
        tick_frame(B_RIGHT); ex_z += 63;
        vectors++; if (p_pos_x !== 17'(ex_x) || p_pos_z !== 17'(ex_z)) begin errors++; $display("FAIL right0 x %0d z %0d exp %0d %0d", p_pos_x, p_pos_z, ex_x, ex_z); end
        tick_frame(B_LEFT); ex_z -= 63;
        vectors++; if (p_pos_z !== 17'(ex_z)) begin errors++; $display("FAIL left0 z %0d exp %0d", p_pos_z, ex_z); end
        tick_frame(B_FWD | B_BACK);
        vectors++; if (p_pos_x !== 17'(ex_x) || p_pos_z !== 17'(ex_z)) begin errors++; $display("FAIL cancel x %0d z %0d exp %0d %0d", p_pos_x, p_pos_z, ex_x, ex_z); end
        repeat (60) tick_frame(B_TR);
        vectors++; if (p_angle_x !== 16'd180) begin errors++; $display("FAIL yaw180 got %0d exp 180", p_angle_x); end
        tick_frame(B_FWD); ex_x -= 64;
        vectors++; if (p_pos_x !== 17'(ex_x) || p_pos_z !== 17'(ex_z)) begin errors++; $display("FAIL fwd180 x %0d z %0d exp %0d %0d", p_pos_x, p_pos_z, ex_x, ex_z); end
        repeat (30) tick_frame(B_TR);
        tick_frame(B_FWD); ex_z += 63;
        vectors++; if (p_pos_x !== 17'(ex_x) || p_pos_z !== 17'(ex_z)) begin errors++; $display("FAIL fwd90 x %0d z %0d exp %0d %0d", p_pos_x, p_pos_z, ex_x, ex_z); end
        repeat (60) tick_frame(B_TR);
        vectors++; if (p_angle_x !== 16'd270) begin errors++; $display("FAIL yaw270 got %0d exp 270", p_angle_x); end
        tick_frame(B_FWD); ex_z -= 64;
        vectors++; if (p_pos_x !== 17'(ex_x) || p_pos_z !== 17'(ex_z)) begin errors++; $display("FAIL fwd270 x %0d z %0d exp %0d %0d", p_pos_x, p_pos_z, ex_x, ex_z); end
        repeat (30) tick_frame(B_TL);
        repeat (10) tick_frame(B_TL);
        vectors++; if (p_angle_x !== 16'd30) begin errors++; $display("FAIL yaw30 got %0d exp 30", p_angle_x); end
        tick_frame(B_FWD); ex_x += 55; ex_z += 32;
        vectors++; if (p_pos_x !== 17'(ex_x) || p_pos_z !== 17'(ex_z)) begin errors++; $display("FAIL fwd30 x %0d z %0d exp %0d %0d", p_pos_x, p_pos_z, ex_x, ex_z); end
        repeat (10) tick_frame(B_TR);
    endtask

    task automatic test_pos_clamp;
        repeat (536) tick_frame(B_BACK);
        vectors++; if (p_pos_x !== 17'd15) begin errors++; $display("FAIL near_zero x %0d exp 15", p_pos_x); end
        tick_frame(B_BACK);
        vectors++; if (p_pos_x !== 17'd0) begin errors++; $display("FAIL clamp_lo x %0d exp 0", p_pos_x); end
        tick_frame(B_BACK);
        vectors++; if (p_pos_x !== 17'd0) begin errors++; $display("FAIL clamp_lo_hold x %0d exp 0", p_pos_x); end
        repeat (1040) tick_frame(B_FWD);
        vectors++; if (p_pos_x !== 17'd65520) begin errors++; $display("FAIL near_max x %0d exp 65520", p_pos_x); end
        tick_frame(B_FWD);
        vectors++; if (p_pos_x !== 17'd65535) begin errors++; $display("FAIL clamp_hi x %0d exp 65535", p_pos_x); end
        tick_frame(B_FWD);
        vectors++; if (p_pos_x !== 17'd65535) begin errors++; $display("FAIL clamp_hi_hold x %0d exp 65535", p_pos_x); end
    endtask

    task automatic test_pitch;
        repeat (19) tick_frame(B_LU);
        vectors++; if (p_angle_y !== 16'sd57) begin errors++; $display("FAIL pitch57 got %0d exp 57", p_angle_y); end
        tick_frame(B_LU);
        vectors++; if (p_angle_y !== 16'sd60) begin errors++; $display("FAIL pitch60 got %0d exp 60", p_angle_y); end
        tick_frame(B_LU);
        vectors++; if (p_angle_y !== 16'sd60) begin errors++; $display("FAIL pitch_clamp_hi got %0d exp 60", p_angle_y); end
        repeat (40) tick_frame(B_LD);
        vectors++; if (p_angle_y !== -16'sd60) begin errors++; $display("FAIL pitch_m60 got %0d exp -60", p_angle_y); end
        tick_frame(B_LD);
        vectors++; if (p_angle_y !== -16'sd60) begin errors++; $display("FAIL pitch_clamp_lo got %0d exp -60", p_angle_y); end
        tick_frame(B_LU | B_LD);
        vectors++; if (p_angle_y !== -16'sd60) begin errors++; $display("FAIL pitch_cancel got %0d exp -60", p_angle_y); end
    endtask

`ifdef GRAVITY_EN
    task automatic test_gravity;
        for (int i = 0; i < 300 && p_pos_y !== 17'd8192; i++) tick_frame('0);
        vectors++; if (p_pos_y !== 17'd8192) begin errors++; $display("FAIL grav_floor y %0d exp 8192", p_pos_y); end
        tick_frame(B_UP);
        vectors++; if (p_pos_y !== 17'd8288) begin errors++; $display("FAIL grav_jump y %0d exp 8288", p_pos_y); end
        tick_frame('0);
        vectors++; if (p_pos_y !== 17'd8380) begin errors++; $display("FAIL grav_rise y %0d exp 8380", p_pos_y); end
        tick_frame(B_UP);
        vectors++; if (p_pos_y !== 17'd8468) begin errors++; $display("FAIL grav_nojump y %0d exp 8468", p_pos_y); end
        tick_frame(B_DN);
        vectors++; if (p_pos_y !== 17'd8552) begin errors++; $display("FAIL grav_down_ign y %0d exp 8552", p_pos_y); end
        for (int i = 0; i < 100 && p_pos_y !== 17'd8192; i++) tick_frame('0);
        vectors++; if (p_pos_y !== 17'd8192) begin errors++; $display("FAIL grav_land y %0d exp 8192", p_pos_y); end
        tick_frame('0);
        vectors++; if (p_pos_y !== 17'd8192) begin errors++; $display("FAIL grav_rest y %0d exp 8192", p_pos_y); end
    endtask
`else
    task automatic test_vertical;
        tick_frame(B_UP);
        vectors++; if (p_pos_y !== 17'd33856) begin errors++; $display("FAIL up y %0d exp 33856", p_pos_y); end
        tick_frame(B_DN);
        vectors++; if (p_pos_y !== 17'd33792) begin errors++; $display("FAIL down y %0d exp 33792", p_pos_y); end
        tick_frame(B_UP | B_DN);
        vectors++; if (p_pos_y !== 17'd33792) begin errors++; $display("FAIL updown y %0d exp 33792", p_pos_y); end
    endtask
`endif

    initial begin
        test_reset;
        test_reset_abort;
        test_latency_drop;
        test_back_to_back;
        test_yaw_wrap;
        test_move;
        test_pos_clamp;
        test_pitch;
`ifdef GRAVITY_EN
        test_gravity;
`else
        test_vertical;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/player_ctrl.md
# player_ctrl

Per-frame player pose integrator upstream of `ppl`. It samples a packed button vector once per frame tick, updates yaw, pitch and position in the fixed-point formats `ppl` consumes (`p_pos_*`, `p_angle_*`), and commits the new pose atomically so the ray pipeline sees one stable pose for a whole frame.

## Interface
Parameters:
- `INIT_X`, default `33<<10`: reset X position.
- `INIT_Y`, default `33<<10`: reset Y position.
- `INIT_Z`, default `49<<10`: reset Z position.
- `INIT_YAW`, default `225`: reset yaw, in degrees.
- `MOVE_SPEED`, default `64`: position LSBs per frame at unit trig.
- `TURN_STEP`, default `3`: degrees per frame.
- `PITCH_MAX`, default `60`: pitch limit, ±degrees.
- `POS_MAX`, default `65535`: upper position clamp. The lower clamp is 0.
- `GRAVITY`, default `4`; `JUMP_VEL`, default `96`; `MAX_FALL`, default `256`; `FLOOR_Y`, default `8<<10`: used only with `GRAVITY_EN`.

Ports:
- `clk` in 1: single clock, which is the `PPL_clk` domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, already in the `clk` domain.
- `btn` in 10: `[0]` fwd, `[1]` back, `[2]` left, `[3]` right, `[4]` turn_l, `[5]` turn_r, `[6]` look_u, `[7]` look_d, `[8]` up, `[9]` down. Level-sensitive, sampled at the tick.
- `p_pos_x`, `p_pos_y`, `p_pos_z` out 17: unsigned. 7 fractional bits; 8 units per block.
- `p_angle_x` out 16: yaw, 0..359.
- `p_angle_y` out 16: pitch, two's complement, −`PITCH_MAX`..`PITCH_MAX`.
- `pose_update` out 1: one-cycle pulse when the pose outputs change.

## Operation
FSM states are `IDLE` → `ROTATE` → `LOOKUP` → `MOVE` → `COMMIT` → `IDLE`.

- **IDLE:** when `frame_tick`=1, latch `btn` into `btn_q` and go to `ROTATE`. In any other state `frame_tick` is ignored; there is no queuing.
- **ROTATE:** update yaw and pitch into working registers.
  - Yaw: turn_l adds `TURN_STEP`; turn_r subtracts it. Both pressed gives no change.
  - Yaw wrap: a result ≥360 has 360 subtracted; a result <0 has 360 added.
  - Pitch: look_u adds `TURN_STEP`, clamped at +`PITCH_MAX`; look_d subtracts it, clamped at −`PITCH_MAX`.
- **LOOKUP:** present the new yaw to `trig_lut`. The LUT output is registered, with 1-cycle latency.
- **MOVE:** cos and sin are signed 8-bit Q1.7, range ±127.
  - Define `c = (MOVE_SPEED*cos) >>> 7` and `s = (MOVE_SPEED*sin) >>> 7`, both arithmetic (floor).
  - fwd: x += c, z += s.
  - back: x −= c, z −= s.
  - right: x −= s, z += c.
  - left: x += s, z −= c.
  - Opposing buttons cancel.
  - Sums are computed in 19-bit signed, then clamped to [0, `POS_MAX`].
  - Y handling is described under Configuration.
- **COMMIT:** copy the working registers to the outputs and pulse `pose_update`.

## Timing
- `frame_tick` is sampled at edge E0. Outputs and `pose_update` are both registered and take their new values at edge E4.
- The FSM is back in `IDLE` at E4, so a tick at E4 is accepted. Ticks at E1–E3 are dropped.
- Outputs never change except at `COMMIT`.
- Reset values: `p_pos_*` = `INIT_*`, `p_angle_x` = `INIT_YAW`, `p_angle_y` = 0, `pose_update` = 0. The FSM resets to `IDLE` and the vertical velocity resets to 0.
- Reset asserted mid-update aborts the update and restores the reset values. No `pose_update` is emitted.

## Configuration
`GRAVITY_EN`:
- **Defined:** a signed 12-bit `vel_y` is maintained.
  - In `MOVE`: vel_y −= `GRAVITY`, floored at −`MAX_FALL`.
  - If up is pressed and y == `FLOOR_Y`, vel_y = `JUMP_VEL`. Jump takes priority over gravity that frame.
  - y += vel_y. If the result is ≤ `FLOOR_Y`, set y = `FLOOR_Y` and vel_y = 0.
  - down is ignored.
- **Undefined:** up adds `MOVE_SPEED` to y and down subtracts it, clamped to [0, `POS_MAX`].
  - `vel_y` and the gravity parameters are not synthesized.

## Structure
- **`player_pkg`** holds the shared definitions:
  - FSM state enum;
  - `BTN_*` bit indices;
  - `POS_W`=17, `ANG_W`=16, `POS_FRAC`=7;
  - `DEG_360`=360.
- **`trig_lut`** is one sub-module.
  - It holds a 91-entry quarter-wave table, `round(127*sin(k°))`.
  - It reconstructs all four quadrants from the table.
  - Input is yaw 0..359. Outputs are `cos` and `sin`, signed 8-bit, registered.

## Test plan
- **Reset:** release reset → x=33792, y=33792, z=50176, yaw=225, pitch=0, `pose_update`=0.
- **Yaw wrap:** yaw=358, turn_l tick → yaw=1 at E4 with a `pose_update` pulse. Yaw=1, turn_r tick → yaw=358.
- **Forward/back movement:** yaw=0, x=1000, fwd tick → x=1063, z unchanged. Yaw=180, fwd → x=1000−64=936. Yaw=90, fwd → z += 63.
- **Position clamp:** yaw=0, x=30, back tick → x=0. x=65500, fwd → x=65535.
- **Pitch clamp and dropped ticks:** pitch=59, look_u → 60; a second look_u tick → 60. A tick at E2 of an update → dropped, only one `pose_update`.
- **Gravity (`GRAVITY_EN`):** y=`FLOOR_Y`, up tick → vel=96, y=`FLOOR_Y`+96. Next tick with no buttons → vel=92, y += 92. Falling eventually lands: y=`FLOOR_Y`, vel=0.
- **No gravity (`GRAVITY_EN` undefined):** up tick → y += 64.
